// File: rtl/shift_sub_divider.sv
// Sequential unsigned restoring divider.
// One shift and one trial subtract per quotient bit; results held in DONE.
module shift_sub_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             seqreset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    SUB,
    DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0] diff;
  logic           ge;
  logic           accept;
  logic           dz;
  logic           last;

  always_comb begin
    diff   = r - {1'b0, d};
    ge     = (r >= {1'b0, d});
    accept = start && (state == IDLE || state == DONE);
    dz     = (divisor == '0);
    last   = (cnt == CW'(1));
  end

  always_comb begin
    state_n = state;
    ready   = 1'b0;
    busy    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        ready = (state == DONE);
        if (start) begin
          state_n = dz ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        busy    = 1'b1;
        state_n = SUB;
      end
      SUB: begin
        busy    = 1'b1;
        state_n = last ? DONE : SHIFT;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge seqreset) begin
    if (seqreset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clock or posedge seqreset) begin
    if (seqreset) begin
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (accept && !dz) begin
            r   <= '0;
            q   <= dividend;
            d   <= divisor;
            cnt <= CW'(WIDTH);
          end else if (accept) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end
        end
        SHIFT: begin
          {r, q} <= {r[WIDTH-1:0], q, 1'b0};
        end
        SUB: begin
          cnt <= cnt - CW'(1);
          if (ge) begin
            r    <= diff;
            q[0] <= 1'b1;
          end
          // the final bit is folded straight into the published result
          if (last) begin
            quotient    <= {q[WIDTH-1:1], ge};
            remainder   <= ge ? diff[WIDTH-1:0] : r[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Bench for shift_sub_divider: arithmetic reference model,
// per-cycle compare, and directed plus random operations.
module tb_shift_sub_divider;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         seqreset;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         ready;
  logic         busy;
  logic         div_by_zero;

  int total = 0;
  int bad = 0;
  int edges = 0;
  int e0 = 0;

  shift_sub_divider #(.WIDTH(W)) dut (
    .clock(clock),
    .seqreset(seqreset),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .ready(ready),
    .busy(busy),
    .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  // reference model: results are plain / and %, timing is a latency counter
  int       m_left = 0;
  bit       m_ready = 0;
  bit       m_busy = 0;
  bit       m_dbz = 0;
  bit [W-1:0] m_q = '0;
  bit [W-1:0] m_r = '0;
  bit [W-1:0] p_q = '0;
  bit [W-1:0] p_r = '0;

  always @(posedge clock or posedge seqreset) begin
    if (seqreset) begin
      m_left  = 0;
      m_ready = 0;
      m_busy  = 0;
      m_dbz   = 0;
      m_q     = '0;
      m_r     = '0;
    end else begin
      edges++;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy  = 0;
          m_ready = 1;
          m_q     = p_q;
          m_r     = p_r;
          m_dbz   = 0;
        end
      end else if (start === 1'b1) begin
        if (divisor == 0) begin
          m_ready = 1;
          m_q     = '1;
          m_r     = dividend;
          m_dbz   = 1;
        end else begin
          m_ready = 0;
          m_busy  = 1;
          m_left  = 2 * W;
          p_q     = dividend / divisor;
          p_r     = dividend % divisor;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("cyc_ready", 32'(ready), 32'(m_ready));
    chk("cyc_busy", 32'(busy), 32'(m_busy));
    chk("cyc_quot", 32'(quotient), 32'(m_q));
    chk("cyc_rem", 32'(remainder), 32'(m_r));
    chk("cyc_dbz", 32'(div_by_zero), 32'(m_dbz));
  end

  task automatic kick(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clock);
    #1;
    e0       = edges;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  task automatic wait_done(input string nm, input int eq, input int er,
                           input int edz, input int elat);
    int guard = 0;
    while (ready !== 1'b1 && guard < 100) begin
      @(posedge clock);
      #1;
      guard++;
    end
    if (guard >= 100) begin
      chk({nm, "_timeout"}, 32'(ready), 32'd1);
    end else begin
      chk({nm, "_lat"}, 32'(edges - e0), 32'(elat));
      chk({nm, "_q"}, 32'(quotient), 32'(eq));
      chk({nm, "_r"}, 32'(remainder), 32'(er));
      chk({nm, "_dz"}, 32'(div_by_zero), 32'(edz));
      chk({nm, "_busy"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int eq,
                        input int er, input int edz, input int elat);
    kick(a, b);
    wait_done(nm, eq, er, edz, elat);
  endtask

  initial begin
    seqreset = 1'b1;
    #3;
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clock);
    seqreset = 1'b0;
    repeat (2) @(negedge clock);

    run_op("d100_7", 8'd100, 8'd7, 14, 2, 0, 16);
    run_op("d255_1", 8'd255, 8'd1, 255, 0, 0, 16);
    run_op("d5_9", 8'd5, 8'd9, 0, 5, 0, 16);
    run_op("d0_3", 8'd0, 8'd3, 0, 0, 0, 16);
    run_op("d200_0", 8'd200, 8'd0, 255, 200, 1, 0);
    run_op("d200_3", 8'd200, 8'd3, 66, 2, 0, 16);

    run_op("d13_3", 8'd13, 8'd3, 4, 1, 0, 16);
    repeat (3) begin
      @(negedge clock);
      dividend = W'($urandom);
      divisor  = W'($urandom);
    end
    run_op("d255_16", 8'd255, 8'd16, 15, 15, 0, 16);

    kick(8'd100, 8'd7);
    repeat (4) @(posedge clock);
    @(negedge clock);
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done("ignore_start", 14, 2, 0, 16);

    kick(8'd100, 8'd7);
    repeat (5) @(posedge clock);
    @(posedge clock);
    #2;
    seqreset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd0);
    chk("mid_rst_q", 32'(quotient), 32'd0);
    chk("mid_rst_r", 32'(remainder), 32'd0);
    @(negedge clock);
    seqreset = 1'b0;
    run_op("d77_8", 8'd77, 8'd8, 9, 5, 0, 16);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      int sel;
      a   = W'($urandom_range(0, 255));
      sel = $urandom_range(0, 9);
      if (sel == 0) b = '0;
      else if (sel < 4) b = W'($urandom_range(1, 15));
      else b = W'($urandom_range(1, 255));
      repeat ($urandom_range(0, 3)) @(negedge clock);
      if (b == 0) run_op("rnd", a, b, 255, int'(a), 1, 0);
      else run_op("rnd", a, b, int'(a / b), int'(a % b), 0, 16);
    end

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
